fft_spectrum: RTL and testbench

- Consumer stage for the FFT magnitude shift-out port.
- Periodically freezes the FFT output latch by driving `shift`, then walks SIZE bins out of `fft_data` one per cycle.
- For each bin, maintains an exponentially averaged magnitude and a peak-hold value in a SIZE-entry register bank.
- Exposes a registered random-access read port for the display/readout logic, plus a frame-complete strobe.

---
 rtl/fft_spectrum_pkg.sv | 38 +++
 rtl/fft_bin_update.sv | 30 +++
 rtl/fft_spectrum.sv | 157 +++++++++++++++
 tb/tb_fft_spectrum.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_spectrum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_spectrum_pkg
// Description : Shared types, constants and the averaging helper for the
//               FFT spectrum consumer stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_spectrum_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2
    } fsm_state_e;

    // Cycles with shift=0 after the last shift pulse; the first one lets the
    // final bin through the delayed write pipe, the second flags completion.
    localparam int unsigned DRAIN_CYCLES = 2;

    // Exponential average step: avg + ((x - avg) >>> shamt).
    // Operands are zero-extended magnitudes (width <= 32); the difference
    // is formed one bit wider so it is always representable. The true result
    // lies between avg and x, so a modulo-2^32 add is exact.
    function automatic logic [31:0] avg_next_f(
        input logic [31:0]  avg,
        input logic [31:0]  x,
        input int unsigned  shamt
    );
        logic signed [32:0] diff;
        logic signed [32:0] step;
        diff = $signed({1'b0, x}) - $signed({1'b0, avg});
        step = diff >>> shamt;
        return avg + step[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_bin_update.sv
`default_nettype none
// ============================================================================
// Module      : fft_bin_update
// Description : Combinational per-bin update: exponential average and
//               peak hold (peak restarts from x when i_clr is set).
// Ports       : i_avg, i_peak  - current bank entry
//               i_x            - new bin magnitude
//               i_clr          - restart peak hold for this frame
//               o_avg_next, o_peak_next - values to write back
// Revision    : 1.0 - initial release
// ============================================================================
module fft_bin_update
    import fft_spectrum_pkg::*;
#(
    parameter int unsigned RN        = 16,
    parameter int unsigned AVG_SHIFT = 3
) (
    input  logic [RN-1:0] i_avg,
    input  logic [RN-1:0] i_peak,
    input  logic [RN-1:0] i_x,
    input  logic          i_clr,
    output logic [RN-1:0] o_avg_next,
    output logic [RN-1:0] o_peak_next
);

    assign o_avg_next  = RN'(avg_next_f(32'(i_avg), 32'(i_x), AVG_SHIFT));
    assign o_peak_next = (i_clr || (i_x > i_peak)) ? i_x : i_peak;

endmodule
`default_nettype wire

// File: rtl/fft_spectrum.sv
`default_nettype none
// ============================================================================
// Module      : fft_spectrum
// Description : Periodically shifts SIZE bins out of the FFT magnitude latch
//               and keeps an averaged and a peak-hold value per bin, with a
//               registered random-access read port.
// Ports       : clk, reset (async, active high), enable
//               shift      - to FFT, 1 = shift latch toward bin 0
//               fft_data   - from FFT, magnitude of latch bin 0 (registered)
//               peak_clr   - request peak-hold restart on the next frame
//               rd_addr -> rd_avg / rd_peak (1-cycle latency)
//               frame_done - pulse after last bin of a frame is written
//               busy       - high in SHIFT or DRAIN
// Revision    : 1.0 - initial release
// ============================================================================
module fft_spectrum
    import fft_spectrum_pkg::*;
#(
    parameter int unsigned RN        = 16,
    parameter int unsigned SIZE      = 32,
    parameter int unsigned AW        = $clog2(SIZE),
    parameter int unsigned PERIOD    = 4096,
    parameter int unsigned AVG_SHIFT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          shift,
    input  logic [RN-1:0] fft_data,
    input  logic          peak_clr,
    input  logic [AW-1:0] rd_addr,
    output logic [RN-1:0] rd_avg,
    output logic [RN-1:0] rd_peak,
    output logic          frame_done,
    output logic          busy
);

    localparam int unsigned   CW            = $clog2(PERIOD);
    localparam logic [CW-1:0] c_PERIOD_LAST = CW'(PERIOD - 1);
    localparam logic [AW-1:0] c_BIN_LAST    = AW'(SIZE - 1);
    localparam logic [0:0]    c_DRAIN_LAST  = 1'(DRAIN_CYCLES - 1);
    localparam logic [1:0]    c_ST_WAIT     = ST_WAIT;
    localparam logic [1:0]    c_ST_SHIFT    = ST_SHIFT;
    localparam logic [1:0]    c_ST_DRAIN    = ST_DRAIN;

    logic [1:0]    r_state;
    logic [CW-1:0] r_period_cnt;
    logic [AW-1:0] r_bin_cnt;
    logic [0:0]    r_drain_cnt;
    logic          r_pend;
    logic          r_clr_frame;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_idx;
    logic [RN-1:0] r_avg  [SIZE];
    logic [RN-1:0] r_peak [SIZE];
    logic [RN-1:0] r_rd_avg;
    logic [RN-1:0] r_rd_peak;

    logic          w_start;
    logic [RN-1:0] w_avg_next;
    logic [RN-1:0] w_peak_next;

    assign w_start    = (r_state == c_ST_WAIT) && (r_period_cnt == c_PERIOD_LAST) && enable;
    // Decoded from registered state so async reset drops them immediately
    assign shift      = (r_state == c_ST_SHIFT);
    assign busy       = (r_state != c_ST_WAIT);
    assign frame_done = (r_state == c_ST_DRAIN) && (r_drain_cnt == c_DRAIN_LAST);
    assign rd_avg     = r_rd_avg;
    assign rd_peak    = r_rd_peak;

    // Frame sequencer, period timer and peak-clear bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_ST_WAIT;
            r_period_cnt <= '0;
            r_bin_cnt    <= '0;
            r_drain_cnt  <= '0;
            r_pend       <= 1'b0;
            r_clr_frame  <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_idx     <= '0;
        end else begin
            // Timer runs in every state so frame starts stay PERIOD apart
            if (w_start)
                r_period_cnt <= '0;
            else if (r_period_cnt != c_PERIOD_LAST)
                r_period_cnt <= r_period_cnt + CW'(1);

            // A request coinciding with the start stays pending for the next frame
            r_pend <= (r_pend && !w_start) || peak_clr;
            if (w_start)
                r_clr_frame <= r_pend;

            // fft_data lags the shift pulse by one cycle
            r_wr_en  <= shift;
            r_wr_idx <= r_bin_cnt;

            case (r_state)
                c_ST_WAIT: begin
                    if (w_start) begin
                        r_state   <= c_ST_SHIFT;
                        r_bin_cnt <= '0;
                    end
                end
                c_ST_SHIFT: begin
                    if (r_bin_cnt == c_BIN_LAST) begin
                        r_state     <= c_ST_DRAIN;
                        r_bin_cnt   <= '0;
                        r_drain_cnt <= '0;
                    end else begin
                        r_bin_cnt <= r_bin_cnt + AW'(1);
                    end
                end
                c_ST_DRAIN: begin
                    if (r_drain_cnt == c_DRAIN_LAST)
                        r_state <= c_ST_WAIT;
                    else
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                end
                default: r_state <= c_ST_WAIT;
            endcase
        end
    end

    fft_bin_update #(
        .RN        (RN),
        .AVG_SHIFT (AVG_SHIFT)
    ) u_bin_update (
        .i_avg       (r_avg[r_wr_idx]),
        .i_peak      (r_peak[r_wr_idx]),
        .i_x         (fft_data),
        .i_clr       (r_clr_frame),
        .o_avg_next  (w_avg_next),
        .o_peak_next (w_peak_next)
    );

    // Bin bank and read port; a same-cycle read sees the pre-write value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SIZE; i++) begin
                r_avg[i]  <= '0;
                r_peak[i] <= '0;
            end
            r_rd_avg  <= '0;
            r_rd_peak <= '0;
        end else begin
            if (r_wr_en) begin
                r_avg[r_wr_idx]  <= w_avg_next;
                r_peak[r_wr_idx] <= w_peak_next;
            end
            r_rd_avg  <= r_avg[rd_addr];
            r_rd_peak <= r_peak[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_spectrum.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_spectrum
// Description : Self-checking bench for fft_spectrum. Two instances share
//               stimulus (AVG_SHIFT 0 and 2); an FFT latch model feeds them
//               and a per-bin reference model predicts avg/peak contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_spectrum;

    localparam int SIZE   = 4;
    localparam int PERIOD = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        peak_clr;
    logic [1:0]  rd_addr;
    logic [15:0] fft_data;

    logic        shift0, shift2, fd0, fd2, busy0, busy2;
    logic [15:0] avg0, peak0, avg2, peak2;

    always #5 clk = ~clk;

    fft_spectrum #(.RN(16), .SIZE(SIZE), .AW(2), .PERIOD(PERIOD), .AVG_SHIFT(0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .shift(shift0), .fft_data(fft_data),
        .peak_clr(peak_clr), .rd_addr(rd_addr), .rd_avg(avg0), .rd_peak(peak0),
        .frame_done(fd0), .busy(busy0)
    );

    fft_spectrum #(.RN(16), .SIZE(SIZE), .AW(2), .PERIOD(PERIOD), .AVG_SHIFT(2)) dut2 (
        .clk(clk), .reset(reset), .enable(enable), .shift(shift2), .fft_data(fft_data),
        .peak_clr(peak_clr), .rd_addr(rd_addr), .rd_avg(avg2), .rd_peak(peak2),
        .frame_done(fd2), .busy(busy2)
    );

    // FFT output latch: tracks the live spectrum while shift=0, shifts toward
    // bin 0 while shift=1; fft_data is a registered copy of latch bin 0.
    logic [15:0] live  [SIZE];
    logic [15:0] latch [SIZE];
    always @(posedge clk) begin
        if (!shift0) begin
            for (int i = 0; i < SIZE; i++) latch[i] <= live[i];
        end else begin
            for (int i = 0; i < SIZE - 1; i++) latch[i] <= latch[i+1];
            latch[SIZE-1] <= 16'd0;
        end
        fft_data <= latch[0];
    end

    // Reference model
    int m_avg0 [SIZE];
    int m_avg2 [SIZE];
    int m_peak [SIZE];
    bit m_pend, m_clr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // avg + floor((x - avg) / 2^k)
    function automatic int ref_avg(input int a, input int x, input int k);
        int d, q;
        d = x - a;
        q = 1 << k;
        if (d >= 0) return a + d / q;
        return a - ((-d + q - 1) / q);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic rand_live();
        for (int b = 0; b < SIZE; b++) live[b] = 16'($urandom_range(0, 65535));
    endtask

    task automatic model_reset();
        for (int b = 0; b < SIZE; b++) begin
            m_avg0[b] = 0;
            m_avg2[b] = 0;
            m_peak[b] = 0;
        end
        m_pend = 1'b0;
        m_clr  = 1'b0;
    endtask

    // Apply the frame that was latched from `live`
    task automatic model_frame();
        for (int b = 0; b < SIZE; b++) begin
            int x;
            x = int'(live[b]);
            m_avg0[b] = x;
            m_avg2[b] = ref_avg(m_avg2[b], x, 2);
            m_peak[b] = (m_clr || x > m_peak[b]) ? x : m_peak[b];
        end
    endtask

    task automatic check_bins();
        for (int b = 0; b < SIZE; b++) begin
            rd_addr = 2'(b);
            tick();
            check($sformatf("avg0[%0d]", b), 32'(avg0), m_avg0[b]);
            check($sformatf("peak0[%0d]", b), 32'(peak0), m_peak[b]);
            check($sformatf("avg2[%0d]", b), 32'(avg2), m_avg2[b]);
            check($sformatf("peak2[%0d]", b), 32'(peak2), m_peak[b]);
        end
    endtask

    task automatic check_avg2_bin0(input string tag, input int exp);
        rd_addr = 2'd0;
        tick();
        check(tag, 32'(avg2), exp);
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (shift0 !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        check("start_timeout", 32'(shift0), 1);
        m_clr  = m_pend;
        m_pend = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (fd0 !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        check("done_timeout", 32'(fd0), 1);
        model_frame();
    endtask

    task automatic run_frame(input bit do_clr);
        wait_start();
        if (do_clr) begin
            tick();
            peak_clr = 1'b1;
            tick();
            peak_clr = 1'b0;
            m_pend   = 1'b1;
        end
        wait_done();
        check_bins();
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b1;
        peak_clr = 1'b0;
        rd_addr  = 2'd0;
        model_reset();
        rand_live();
        live[0] = 16'd400;

        // Reset state
        repeat (3) tick();
        check("rst_shift", 32'(shift0), 0);
        check("rst_busy", 32'(busy0), 0);
        check("rst_done", 32'(fd0), 0);
        check("rst_avg", 32'(avg2), 0);
        check("rst_peak", 32'(peak2), 0);

        // Frame timing from reset release
        reset = 1'b0;
        cyc   = 0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            check($sformatf("shift@%0d", k), 32'(shift0), 32'((k >= 16 && k <= 19) ? 1 : 0));
            check($sformatf("busy@%0d", k), 32'(busy0), 32'((k >= 16 && k <= 21) ? 1 : 0));
            check($sformatf("done@%0d", k), 32'(fd0), 32'((k == 21) ? 1 : 0));
            if (k == 16) begin
                m_clr  = m_pend;
                m_pend = 1'b0;
            end
            if (k == 21) begin
                model_frame();
                rand_live();
                live[0] = 16'd400;
            end
        end
        check_bins();
        check_avg2_bin0("avg_f1", 100);

        // Second frame starts exactly PERIOD clocks after the first
        while (cyc < 31) tick();
        check("shift@31", 32'(shift0), 0);
        tick();
        check("shift@32", 32'(shift0), 1);
        m_clr  = m_pend;
        m_pend = 1'b0;
        wait_done();
        check_bins();
        check_avg2_bin0("avg_f2", 175);

        rand_live();
        live[0] = 16'd400;
        run_frame(1'b0);
        check_avg2_bin0("avg_f3", 231);

        // Step down: 231 + floor(-231/4) = 231 - 58
        rand_live();
        live[0] = 16'd0;
        live[1] = 16'd500;
        run_frame(1'b0);
        check_avg2_bin0("avg_f4", 173);

        // Peak clear requested mid-frame applies to the following frame
        rand_live();
        live[1] = 16'd300;
        run_frame(1'b1);
        rand_live();
        live[1] = 16'd300;
        run_frame(1'b0);
        rand_live();
        run_frame(1'b0);

        // Enable dropped in the second SHIFT cycle
        rand_live();
        wait_start();
        tick();
        enable = 1'b0;
        wait_done();
        check_bins();
        for (int k = 0; k < 100; k++) begin
            tick();
            if (k % 10 == 9) check($sformatf("hold_shift@%0d", k), 32'(shift0), 0);
        end
        rand_live();
        enable = 1'b1;
        tick();
        check("reenable_shift", 32'(shift0), 1);
        run_frame(1'b0);

        // Async reset in SHIFT cycle 2
        rand_live();
        wait_start();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("arst_shift", 32'(shift0), 0);
        check("arst_busy", 32'(busy0), 0);
        tick();
        reset = 1'b0;
        cyc   = 0;
        model_reset();
        for (int b = 0; b < SIZE; b++) begin
            rd_addr = 2'(b);
            tick();
            check($sformatf("arst_avg2[%0d]", b), 32'(avg2), 0);
            check($sformatf("arst_peak0[%0d]", b), 32'(peak0), 0);
        end
        while (cyc < 15) tick();
        check("arst_shift@15", 32'(shift0), 0);
        tick();
        check("arst_shift@16", 32'(shift0), 1);
        wait_done();
        check_bins();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
